xlink_tx_serializer: RTL and testbench
======================================

XLINK_TX_SERIALIZER -- requirements
Module: xlink_tx_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: token FIFO depth in entries (power of two, at least 2).
REQ-002 SHALL have parameter DLY_W, default 8: width of bit_delay.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_token_buf_in  input  9  token from link controller; bit 8 = control flag, bits 7:0 = payload.
REQ-006 SHALL have port tx_buf_wen  input  1  write strobe: one token per asserted cycle; no backpressure.
REQ-007 SHALL have port tx_enable  input  1  permits new tokens to start transmission.
REQ-008 SHALL have port bit_delay  input  DLY_W  clk cycles between successive wire transitions, minus one.
REQ-009 SHALL have port clr_overflow  input  1  clears the overflow flag.
REQ-010 SHALL have port link_out  output  2  2-wire line: bit 0 = wire0, bit 1 = wire1.
REQ-011 SHALL have port tx_busy  output  1  high while a token is being serialized.
REQ-012 SHALL have port fifo_level  output  log2(DEPTH)+1  number of tokens held in the FIFO.
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-014 A write SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-015 A write to a full FIFO without a same-cycle pop SHALL be dropped and SHALL set overflow the next cycle; FIFO contents SHALL be unchanged.
REQ-016 overflow SHALL stay set until clr_overflow; a simultaneous drop and clr_overflow SHALL leave overflow set.
REQ-017 fifo_level SHALL be registered and exact; it SHALL be unchanged on a simultaneous accepted write and pop.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH.
REQ-019 The FSM SHALL have the states IDLE, SHIFT and GAP.
REQ-020 IDLE: when fifo_level>0 and tx_enable=1, the block SHALL pop the head token, load a 9-bit shift register, load the bit counter to 9, set tx_busy, and go to SHIFT.
REQ-021 SHIFT: the block SHALL toggle wire1 if the current bit is 1 and wire0 if it is 0, then load the delay counter with bit_delay, decrement the bit counter, and go to GAP.
REQ-022 Bit order SHALL be bit 8 (flag) first, then bits 0 through 7 (LSB first).
REQ-023 GAP: the block SHALL count the delay counter down to 0, then go to SHIFT if bits remain, otherwise to IDLE with tx_busy cleared.
REQ-024 bit_delay SHALL be sampled on each SHIFT entry, so a change takes effect from the next bit.
REQ-025 Consecutive transitions SHALL be exactly bit_delay+2 clk cycles apart, including across token boundaries when the next token is already present.
REQ-026 A token written at cycle t into an empty, idle FIFO SHALL produce its first transition at t+2 (pop at t+1).
REQ-027 Deasserting tx_enable SHALL NOT abort an in-flight token; the block SHALL stop only in IDLE. The FIFO SHALL keep accepting writes meanwhile.
REQ-028 link_out SHALL be registered, and exactly one wire SHALL change per transition.
REQ-029 The 9 transitions of a token SHALL toggle wire1 popcount(token) times and wire0 9-popcount(token) times.

Reset
REQ-030 On reset_n low, asynchronously: link_out=2'b00, FIFO empty, fifo_level=0, overflow=0, tx_busy=0, state IDLE, and all counters and pointers 0.
REQ-031 Reset mid-token SHALL discard the token and all queued tokens; no further transitions SHALL occur until a new write after reset release.

Verification
REQ-032 Scenario, single token: write 9'h0A5 with bit_delay=0 -> transitions start 2 cycles later, 2 cycles apart; wires toggled in order 0,1,0,1,0,0,1,0,1; link_out ends at 2'b01.
REQ-033 Scenario, back-to-back: write 9'h1FF then 9'h000 with bit_delay=3 -> 18 transitions, uniformly 5 cycles apart; wire1 toggles 9 times, then wire0 toggles 9 times.
REQ-034 Scenario, overflow: tx_enable=0, 17 writes with DEPTH=16 -> fifo_level=16, overflow=1, 17th token absent; clr_overflow -> overflow=0; tx_enable=1 -> the 16 tokens are sent in order.
REQ-035 Scenario, full with simultaneous pop: FIFO full, write in the pop cycle -> write accepted, fifo_level stays 16, overflow stays 0.
REQ-036 Scenario, enable drop: tx_enable falls after the 3rd transition -> remaining 6 transitions complete, then idle with the FIFO intact.
REQ-037 Scenario, reset mid-token: reset_n pulsed low after the 4th transition -> link_out=00, fifo_level=0, tx_busy=0 immediately, and the line stays quiet afterwards.

Source files
------------

// File: rtl/xlink_tx_serializer_if.sv
// Link-controller side bundle of the xlink transmit serializer: token write
// port, line control inputs and the line/status outputs.
interface xlink_tx_serializer_if #(
  parameter int DEPTH = 16,
  parameter int DLY_W = 8
) ();

  logic [8:0]               tx_token_buf_in;
  logic                     tx_buf_wen;
  logic                     tx_enable;
  logic [DLY_W-1:0]         bit_delay;
  logic                     clr_overflow;
  logic [1:0]               link_out;
  logic                     tx_busy;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     overflow;

  // Link controller: pushes tokens and steers the line
  modport master (
    output tx_token_buf_in,
    output tx_buf_wen,
    output tx_enable,
    output bit_delay,
    output clr_overflow,
    input  link_out,
    input  tx_busy,
    input  fifo_level,
    input  overflow
  );

  // Serializer: consumes tokens and drives the 2-wire line
  modport slave (
    input  tx_token_buf_in,
    input  tx_buf_wen,
    input  tx_enable,
    input  bit_delay,
    input  clr_overflow,
    output link_out,
    output tx_busy,
    output fifo_level,
    output overflow
  );

endinterface

// File: rtl/xlink_tx_serializer.sv
// Transmit side of a 2-wire transition-coded link. Tokens (flag + byte) are
// queued in a small FIFO and sent one bit per line transition: a 1 toggles
// wire1, a 0 toggles wire0. The flag bit goes first, then the payload LSB
// first. Transitions are spaced bit_delay+2 clocks apart, and a queued token
// follows the previous one with no extra idle cycle.
module xlink_tx_serializer #(
  parameter int DEPTH = 16,
  parameter int DLY_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  xlink_tx_serializer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q;
  logic             overflow_q;
  logic [8:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic [DLY_W-1:0] dly_cnt_q;
  logic [1:0]       link_q;

  logic             pop;
  logic             do_shift;
  logic             can_pop;
  logic             full;
  logic             wr_accept;
  logic             wr_drop;
  logic [8:0]       head;

  assign full      = (level_q == LW'(DEPTH));
  assign can_pop   = (level_q != '0) && bus.tx_enable;
  assign wr_accept = bus.tx_buf_wen && (!full || pop);
  assign wr_drop   = bus.tx_buf_wen && full && !pop;
  assign head      = mem[rd_ptr];

  // Token storage; pointers and level carry the valid state, so no reset here
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.tx_token_buf_in;
    end
  end

  // FIFO pointers and occupancy; a write and pop together leave the level alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_accept, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky drop flag; a fresh drop wins over a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (wr_drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus pop/shift strobes; at the end of a token's last gap the
  // next queued token is popped directly so spacing stays uniform
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    do_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        state_d  = GAP;
      end
      GAP: begin
        if (dly_cnt_q == '0) begin
          if (bit_cnt_q != 4'd0) begin
            state_d = SHIFT;
          end else if (can_pop) begin
            pop     = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit/delay counters and the line; the flag is parked at
  // bit 0 so a plain right shift yields flag then payload LSB first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dly_cnt_q <= '0;
      link_q    <= 2'b00;
    end else if (pop) begin
      shift_q   <= {head[7:0], head[8]};
      bit_cnt_q <= 4'd9;
    end else if (do_shift) begin
      if (shift_q[0]) begin
        link_q[1] <= ~link_q[1];
      end else begin
        link_q[0] <= ~link_q[0];
      end
      shift_q   <= {1'b0, shift_q[8:1]};
      bit_cnt_q <= bit_cnt_q - 4'd1;
      dly_cnt_q <= bus.bit_delay;
    end else if ((state_q == GAP) && (dly_cnt_q != '0)) begin
      dly_cnt_q <= dly_cnt_q - DLY_W'(1);
    end
  end

  assign bus.link_out   = link_q;
  assign bus.tx_busy    = (state_q != IDLE);
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_xlink_tx_serializer.sv
// Self-checking bench for xlink_tx_serializer. A line monitor logs every
// transition (cycle, wire); the reference model expands each queued token
// into its expected bit sequence, and timing follows from the write cycle and
// the bit_delay+2 spacing.
module tb_xlink_tx_serializer;

  localparam int DEPTH = 16;
  localparam int DLY_W = 8;

  logic clk = 1'b0;
  logic reset_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int obs_t[$];
  int obs_w[$];
  int exp_bits[$];
  logic [1:0] prev_link = 2'b00;
  logic [1:0] mon_diff;

  xlink_tx_serializer_if #(.DEPTH(DEPTH), .DLY_W(DLY_W)) bus ();

  xlink_tx_serializer #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used as the time base for expected transition cycles
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: log which wire moved and on which edge (2 = both moved)
  always @(negedge clk) begin
    mon_diff = bus.link_out ^ prev_link;
    if (mon_diff != 2'b00) begin
      obs_t.push_back(cyc);
      obs_w.push_back(mon_diff == 2'b10 ? 1 : (mon_diff == 2'b01 ? 0 : 2));
      prev_link = bus.link_out;
    end
  end

  // Safety net in case the bench itself wedges
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: flag bit first, then payload bits 0..7
  task automatic addToken(input logic [8:0] tok);
    exp_bits.push_back(int'(tok[8]));
    for (int b = 0; b < 8; b++) exp_bits.push_back(int'(tok[b]));
  endtask

  // Called at a negedge; the write is sampled by the next rising edge
  task automatic applyStimulus(input logic [8:0] tok);
    bus.tx_token_buf_in = tok;
    bus.tx_buf_wen      = 1'b1;
    @(negedge clk);
    bus.tx_buf_wen      = 1'b0;
  endtask

  task automatic clearObs();
    @(posedge clk);
    obs_t.delete();
    obs_w.delete();
    @(negedge clk);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((bus.tx_busy || (bus.fifo_level != 0 && bus.tx_enable)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkTrace(input string tag, input int start, input int bd);
    checkOutput({tag, "_count"}, obs_t.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < obs_t.size(); i++) begin
      checkOutput({tag, "_wire"}, obs_w[i], exp_bits[i]);
      checkOutput({tag, "_time"}, obs_t[i], start + i * (bd + 2));
    end
  endtask

  initial begin
    int start;
    int n;
    int bd;
    logic [8:0] tok;
    logic [8:0] tok_b;

    reset_n             = 1'b0;
    bus.tx_token_buf_in = '0;
    bus.tx_buf_wen      = 1'b0;
    bus.tx_enable       = 1'b1;
    bus.bit_delay       = '0;
    bus.clr_overflow    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_link", bus.link_out, 2'b00);
    checkOutput("rst_level", bus.fifo_level, 0);
    checkOutput("rst_ovf", bus.overflow, 0);
    checkOutput("rst_busy", bus.tx_busy, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single token 0x0A5, bit_delay 0
    clearObs();
    exp_bits.delete();
    bus.bit_delay = 0;
    addToken(9'h0A5);
    start = cyc + 3;
    applyStimulus(9'h0A5);
    waitIdle("single");
    checkTrace("single", start, 0);
    checkOutput("single_link", bus.link_out, 2'b01);

    // Back-to-back 0x1FF then 0x000, bit_delay 3
    clearObs();
    exp_bits.delete();
    bus.bit_delay = 3;
    addToken(9'h1FF);
    addToken(9'h000);
    start = cyc + 3;
    applyStimulus(9'h1FF);
    applyStimulus(9'h000);
    waitIdle("b2b");
    checkTrace("b2b", start, 3);

    // Random bursts with random spacing
    for (int r = 0; r < 4; r++) begin
      n  = $urandom_range(1, 5);
      bd = $urandom_range(0, 4);
      clearObs();
      exp_bits.delete();
      bus.bit_delay = DLY_W'(bd);
      start = cyc + 3;
      for (int k = 0; k < n; k++) begin
        tok = 9'($urandom);
        addToken(tok);
        applyStimulus(tok);
      end
      waitIdle("rand");
      checkTrace("rand", start, bd);
    end

    // Overflow: fill with transmission held off, one extra write is dropped
    clearObs();
    exp_bits.delete();
    bus.bit_delay = 0;
    bus.tx_enable = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tok = 9'($urandom);
      if (k < 16) addToken(tok);
      applyStimulus(tok);
    end
    checkOutput("ovf_level", bus.fifo_level, 16);
    checkOutput("ovf_set", bus.overflow, 1);
    bus.clr_overflow = 1'b1;
    applyStimulus(9'h1AB);
    bus.clr_overflow = 1'b0;
    checkOutput("ovf_drop_clr", bus.overflow, 1);
    checkOutput("ovf_level2", bus.fifo_level, 16);
    bus.clr_overflow = 1'b1;
    @(negedge clk);
    bus.clr_overflow = 1'b0;
    checkOutput("ovf_clr", bus.overflow, 0);
    bus.tx_enable = 1'b1;
    start = cyc + 2;
    waitIdle("ovf");
    checkTrace("ovf", start, 0);
    checkOutput("ovf_empty", bus.fifo_level, 0);

    // Full FIFO with a write landing in the pop cycle
    clearObs();
    exp_bits.delete();
    bus.tx_enable = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tok = 9'($urandom);
      addToken(tok);
      applyStimulus(tok);
    end
    tok = 9'($urandom);
    addToken(tok);
    bus.tx_enable = 1'b1;
    start = cyc + 2;
    applyStimulus(tok);
    checkOutput("fullpop_level", bus.fifo_level, 16);
    checkOutput("fullpop_ovf", bus.overflow, 0);
    waitIdle("fullpop");
    checkTrace("fullpop", start, 0);

    // Enable dropped mid-token: the token finishes, the next one waits
    clearObs();
    exp_bits.delete();
    bus.bit_delay = 1;
    tok   = 9'($urandom);
    tok_b = 9'($urandom);
    addToken(tok);
    start = cyc + 3;
    applyStimulus(tok);
    applyStimulus(tok_b);
    n = 0;
    while (obs_t.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("endrop_wait", 32'(n < 200), 32'd1);
    bus.tx_enable = 1'b0;
    checkOutput("endrop_busy", bus.tx_busy, 1);
    waitIdle("endrop");
    checkTrace("endrop", start, 1);
    checkOutput("endrop_level", bus.fifo_level, 1);
    checkOutput("endrop_idle", bus.tx_busy, 0);
    clearObs();
    exp_bits.delete();
    addToken(tok_b);
    bus.tx_enable = 1'b1;
    start = cyc + 2;
    waitIdle("enresume");
    checkTrace("enresume", start, 1);

    // Reset in the middle of a token with more queued behind it
    clearObs();
    bus.bit_delay = 2;
    for (int k = 0; k < 3; k++) applyStimulus(9'($urandom));
    n = 0;
    while (obs_t.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_wait", 32'(n < 200), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_link", bus.link_out, 2'b00);
    checkOutput("midrst_level", bus.fifo_level, 0);
    checkOutput("midrst_busy", bus.tx_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clearObs();
    repeat (40) @(negedge clk);
    checkOutput("midrst_quiet", obs_t.size(), 0);
    checkOutput("midrst_level2", bus.fifo_level, 0);

    // Fresh token after reset release
    exp_bits.delete();
    bus.bit_delay = 0;
    tok = 9'($urandom);
    addToken(tok);
    start = cyc + 3;
    applyStimulus(tok);
    waitIdle("postrst");
    checkTrace("postrst", start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
